// File: rtl/rr_mux_arb_pkg.sv
// Shared constants and helpers for the round-robin registered selector.
package rr_mux_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Source-index width never collapses to zero, even for a single channel.
    function automatic int sw_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_arb_arbiter.sv
// Grant generator: round-robin pointer register plus combinational priority scan.
module rr_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int RR = ARB_RR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic                  adv,
    input  logic [sw_of(N)-1:0]   adv_idx,
    output logic [N-1:0]          grant
);

    localparam int SW = sw_of(N);

    logic [SW-1:0] ptr;
    int unsigned   idx;
    logic          found;

    // Scan starts at ptr in RR mode, at 0 in fixed-priority mode.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = k;
            if (RR == ARB_RR) begin
                idx = k + 32'(ptr);
                if (idx >= N) idx = idx - N;
            end
            if (!found && req[idx[SW-1:0]]) begin
                grant[idx[SW-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (RR == ARB_RR && adv) begin
            ptr <= (adv_idx == SW'(N - 1)) ? '0 : adv_idx + SW'(1);
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-input registered selector with valid/ready handshake and round-robin or fixed arbitration.
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 2,
    parameter int RR    = ARB_RR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          in_valid,
    input  logic [N*WIDTH-1:0]    in_data,
    output logic [N-1:0]          in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [sw_of(N)-1:0]   out_src,
    input  logic                  out_ready
);

    localparam int SW = sw_of(N);

    logic [N-1:0]     grant;
    logic             ld;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic [SW-1:0]    sel_idx;

    rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .adv     (xfer),
        .adv_idx (sel_idx),
        .grant   (grant)
    );

    assign ld       = !out_valid || out_ready;
    assign in_ready = (ld && !rst) ? grant : '0;
    // grant is a subset of in_valid, so any ready bit is a transfer.
    assign xfer     = |in_ready;

    always_comb begin
        sel_data = '0;
        sel_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
                sel_idx  = sel_idx | SW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (ld) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= sel_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed self-checking bench for rr_mux_arb across RR, fixed-priority, N=3 and N=1 configurations.
module tb_rr_mux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // N=4 round-robin
    logic          a_rst, a_ordy, a_ovld;
    logic [3:0]    a_vld, a_rdy;
    logic [127:0]  a_data;
    logic [31:0]   a_odata;
    logic [1:0]    a_src;
    // N=4 fixed priority
    logic          f_rst, f_ordy, f_ovld;
    logic [3:0]    f_vld, f_rdy;
    logic [127:0]  f_data;
    logic [31:0]   f_odata;
    logic [1:0]    f_src;
    // N=3 round-robin
    logic          w_rst, w_ordy, w_ovld;
    logic [2:0]    w_vld, w_rdy;
    logic [95:0]   w_data;
    logic [31:0]   w_odata;
    logic [1:0]    w_src;
    // N=1 pipe
    logic          p_rst, p_ordy, p_ovld;
    logic [0:0]    p_vld, p_rdy, p_src;
    logic [7:0]    p_data, p_odata;

    rr_mux_arb #(.WIDTH(32), .N(4), .RR(1)) u_a (
        .clk(clk), .rst(a_rst), .in_valid(a_vld), .in_data(a_data), .in_ready(a_rdy),
        .out_valid(a_ovld), .out_data(a_odata), .out_src(a_src), .out_ready(a_ordy));
    rr_mux_arb #(.WIDTH(32), .N(4), .RR(0)) u_f (
        .clk(clk), .rst(f_rst), .in_valid(f_vld), .in_data(f_data), .in_ready(f_rdy),
        .out_valid(f_ovld), .out_data(f_odata), .out_src(f_src), .out_ready(f_ordy));
    rr_mux_arb #(.WIDTH(32), .N(3), .RR(1)) u_w (
        .clk(clk), .rst(w_rst), .in_valid(w_vld), .in_data(w_data), .in_ready(w_rdy),
        .out_valid(w_ovld), .out_data(w_odata), .out_src(w_src), .out_ready(w_ordy));
    rr_mux_arb #(.WIDTH(8), .N(1), .RR(1)) u_p (
        .clk(clk), .rst(p_rst), .in_valid(p_vld), .in_data(p_data), .in_ready(p_rdy),
        .out_valid(p_ovld), .out_data(p_odata), .out_src(p_src), .out_ready(p_ordy));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; a_vld = 4'b1111; a_ordy = 1'b1;
        a_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (a_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0000", a_rdy); end
            n_checks++;
            if (a_ovld !== 1'b0 || a_odata !== 32'h0 || a_src !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_out got v=%b d=%h s=%0d exp v=0 d=0 s=0", a_ovld, a_odata, a_src);
            end
        end
        a_rst = 1'b0;
        #1;
        n_checks++;
        if (a_rdy !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=0001", a_rdy); end
    endtask

    task automatic test_rr_fairness();
        logic [3:0]  exp_rdy;
        logic [31:0] exp_d;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            exp_d   = 32'hA0 + 32'(k % 4);
            n_checks++;
            if (a_rdy !== exp_rdy) begin n_fail++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", k, a_rdy, exp_rdy); end
            step();
            n_checks++;
            if (a_ovld !== 1'b1 || a_odata !== exp_d || a_src !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL rr_out[%0d] got v=%b d=%h s=%0d exp v=1 d=%h s=%0d", k, a_ovld, a_odata, a_src, exp_d, k % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        a_vld  = 4'b0100;
        a_data = {32'hA3, 32'hDEADBEEF, 32'hA1, 32'hA0};
        #1;
        n_checks++;
        if (a_rdy !== 4'b0100) begin n_fail++; $display("FAIL bp_grant got=%b exp=0100", a_rdy); end
        step();
        a_vld  = 4'b1111;
        a_ordy = 1'b0;
        a_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (a_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", c, a_rdy); end
            n_checks++;
            if (a_ovld !== 1'b1 || a_odata !== 32'hDEADBEEF || a_src !== 2'd2) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d exp v=1 d=deadbeef s=2", c, a_ovld, a_odata, a_src);
            end
            step();
        end
        a_ordy = 1'b1;
        #1;
        n_checks++;
        if (a_rdy !== 4'b1000) begin n_fail++; $display("FAIL bp_ptr_after_stall got=%b exp=1000", a_rdy); end
        step();
        n_checks++;
        if (a_odata !== 32'hA3 || a_src !== 2'd3) begin
            n_fail++; $display("FAIL bp_drain got d=%h s=%0d exp d=a3 s=3", a_odata, a_src);
        end
        a_vld = 4'b0000;
        step();
        n_checks++;
        if (a_ovld !== 1'b0) begin n_fail++; $display("FAIL bp_empty got v=%b exp v=0", a_ovld); end
    endtask

    task automatic test_fixed_priority();
        f_rst = 1'b1; f_vld = 4'b1010; f_ordy = 1'b1;
        f_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        step(); step();
        f_rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++;
            if (f_rdy !== 4'b0010) begin n_fail++; $display("FAIL fp_in_ready[%0d] got=%b exp=0010", c, f_rdy); end
            step();
            n_checks++;
            if (f_ovld !== 1'b1 || f_odata !== 32'hA1 || f_src !== 2'd1) begin
                n_fail++;
                $display("FAIL fp_out[%0d] got v=%b d=%h s=%0d exp v=1 d=a1 s=1", c, f_ovld, f_odata, f_src);
            end
        end
    endtask

    task automatic test_wrap();
        w_rst = 1'b1; w_vld = 3'b000; w_ordy = 1'b1;
        w_data = {32'hB2, 32'hB1, 32'hB0};
        step();
        w_rst = 1'b0;
        w_vld = 3'b010;
        step();
        n_checks++;
        if (w_odata !== 32'hB1 || w_src !== 2'd1) begin
            n_fail++; $display("FAIL wrap_first got d=%h s=%0d exp d=b1 s=1", w_odata, w_src);
        end
        w_vld = 3'b001;
        #1;
        n_checks++;
        if (w_rdy !== 3'b001) begin n_fail++; $display("FAIL wrap_grant got=%b exp=001", w_rdy); end
        step();
        n_checks++;
        if (w_ovld !== 1'b1 || w_odata !== 32'hB0 || w_src !== 2'd0) begin
            n_fail++; $display("FAIL wrap_out got v=%b d=%h s=%0d exp v=1 d=b0 s=0", w_ovld, w_odata, w_src);
        end
        w_vld = 3'b111;
        #1;
        n_checks++;
        if (w_rdy !== 3'b010) begin n_fail++; $display("FAIL wrap_ptr got=%b exp=010", w_rdy); end
        w_vld = 3'b000;
        step();
        n_checks++;
        if (w_ovld !== 1'b0 || w_odata !== 32'hB0 || w_src !== 2'd0) begin
            n_fail++; $display("FAIL wrap_idle got v=%b d=%h s=%0d exp v=0 d=b0 s=0", w_ovld, w_odata, w_src);
        end
    endtask

    task automatic test_pipe_reset();
        p_rst = 1'b1; p_vld = 1'b0; p_ordy = 1'b1; p_data = 8'h00;
        step();
        p_rst = 1'b0;
        p_vld = 1'b1; p_data = 8'h11;
        step();
        n_checks++;
        if (p_ovld !== 1'b1 || p_odata !== 8'h11 || p_src !== 1'b0) begin
            n_fail++; $display("FAIL pipe_11 got v=%b d=%h s=%0d exp v=1 d=11 s=0", p_ovld, p_odata, p_src);
        end
        p_data = 8'h22;
        step();
        n_checks++;
        if (p_ovld !== 1'b1 || p_odata !== 8'h22) begin
            n_fail++; $display("FAIL pipe_22 got v=%b d=%h exp v=1 d=22", p_ovld, p_odata);
        end
        p_rst = 1'b1; p_data = 8'h33;
        #1;
        n_checks++;
        if (p_rdy !== 1'b0) begin n_fail++; $display("FAIL pipe_rst_ready got=%b exp=0", p_rdy); end
        step();
        n_checks++;
        if (p_ovld !== 1'b0 || p_odata !== 8'h00 || p_src !== 1'b0) begin
            n_fail++; $display("FAIL pipe_rst got v=%b d=%h s=%0d exp v=0 d=00 s=0", p_ovld, p_odata, p_src);
        end
        p_rst = 1'b0;
        step();
        n_checks++;
        if (p_ovld !== 1'b1 || p_odata !== 8'h33) begin
            n_fail++; $display("FAIL pipe_resume got v=%b d=%h exp v=1 d=33", p_ovld, p_odata);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_vld = '0; a_data = '0; a_ordy = 1'b0;
        f_rst = 1'b1; f_vld = '0; f_data = '0; f_ordy = 1'b0;
        w_rst = 1'b1; w_vld = '0; w_data = '0; w_ordy = 1'b0;
        p_rst = 1'b1; p_vld = '0; p_data = '0; p_ordy = 1'b0;
        step();
        test_reset();
        test_rr_fairness();
        test_backpressure();
        test_fixed_priority();
        test_wrap();
        test_pipe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-input, WIDTH-bit registered selector with per-channel valid/ready handshake.
- Successor to the fixed 2:1 32-bit operand mux in the ALU datapath.
- Selects among N producers by round-robin or fixed priority, registers the chosen word, and reports which channel it came from.
- Sits between operand/result sources and the ALU input or writeback stage.

Parameters:
- WIDTH, 32, data width in bits per channel (>=1).
- N, 2, number of input channels (>=1).
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SW, max(1,clog2(N)), width of the source-index field (derived, not overridden).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  one-hot (or zero) accept strobe per channel.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_src  output  SW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the output word this cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0.
  - Any held word is dropped.
  - in_ready is all-zero during any cycle with rst=1.
- Load enable: ld = !out_valid || out_ready. Gives full throughput: one word per cycle with out_ready held high.
- Grant, combinational from in_valid and ptr:
  - RR=1: first valid channel scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - RR=0: lowest-index valid channel; ptr is unused.
  - No valid channel gives grant=0.
- in_ready[i] = ld && grant[i] && !rst. At most one bit is set. in_ready depends combinationally on in_valid and out_ready; producers must not make in_valid depend on in_ready.
- Transfer on channel i when in_valid[i] && in_ready[i]. Next edge: out_data <= channel i word, out_src <= i, out_valid <= 1.
- ld=1 with no valid channel: out_valid <= 0, out_data and out_src hold their values.
- out_valid=1 && out_ready=0: out_valid, out_data and out_src hold stable; all in_ready are 0.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Pointer (RR=1):
  - After a transfer on channel i, ptr <= i+1, wrapping N-1 to 0.
  - No transfer: ptr holds.
- Fairness: with all N channels continuously valid and out_ready=1, each channel is granted exactly once per N cycles.
- N=1: SW=1, out_src is always 0, ptr stays 0, and the block acts as a registered pipe stage.
- Simultaneous pop and push (out_valid=1, out_ready=1, a valid input present): the new word replaces the old one at the same edge with no bubble.
- Reset mid-operation:
  - A word held on the output is discarded.
  - A transfer asserted in the reset cycle is not accepted, since in_ready=0.
- The block never inspects in_data except through the selected slice. No arithmetic is performed on the data.

Decomposition:
- Shared package/header holds:
  - the clog2 helper function;
  - the SW derivation;
  - the arbitration-mode constants ARB_FIXED=0 and ARB_RR=1.
- Sub-module rr_arbiter (parameters N, RR) contains the pointer register and the combinational grant.
  - Inputs: clk, rst, req[N], adv (transfer occurred), adv_idx.
  - Output: grant[N].
- The top level contains only the data-select (AND-OR on grant), the output register and the handshake logic.

Test Plan:
- Reset: N=4, WIDTH=32, drive all in_valid=1 with rst=1 for 2 cycles -> in_ready=0000, out_valid=0, out_data=0, out_src=0; first grant after release is channel 0.
- Round-robin fairness: N=4, RR=1, all valid, data_i=32'hA0+i, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0…, out_src 0,1,2,3,0.
- Fixed priority: N=4, RR=0, in_valid=1010 constant -> channel 1 always granted, out_src=1 every cycle; channel 3 is never serviced.
- Backpressure: single transfer of 32'hDEADBEEF from ch2, then out_ready=0 for 5 cycles -> out_valid=1 and out_data=DEADBEEF stable; in_ready=0; ptr unchanged until the word is drained.
- Wrap and sparse requests: N=3, RR=1, ptr=2 after ch1 transfer, in_valid=001 -> ch0 granted (wrap) and ptr becomes 1; then in_valid=000 -> out_valid drops next cycle.
- N=1 pipe with mid-stream reset: N=1, WIDTH=8, stream 8'h11,8'h22, assert rst with 8'h22 held -> next cycle out_valid=0, out_data=0.
